// File: rtl/mmc1_sxrom_mapper_if.sv
// rtl/mmc1_sxrom_mapper_if.sv - CPU/PPU bus bundle for the MMC1 SxROM mapper
//
// Purpose: groups the CPU-side, PPU-side and mapper-output signals of
// mmc1_sxrom_mapper so the mapper and its host connect through one port.
// Signals:
//   ce          CPU-cycle enable
//   flags[31:0] cartridge flags (bit 15 = CHR is RAM)
//   prg_ain     CPU address          prg_read/prg_write  CPU strobes
//   prg_din     CPU write data       prg_aout/prg_allow  linear PRG address / access permit
//   chr_ain     PPU address          chr_aout/chr_allow  linear CHR address / write permit
//   vram_a10    CIRAM A10            vram_ce             route to internal VRAM
//   cfg_commit  one-clk pulse after a serial register commit
// Modports: master drives the CPU/PPU side, slave is the mapper.

interface mmc1_sxrom_mapper_if;
    logic        ce;
    logic [31:0] flags;
    logic [15:0] prg_ain;
    logic        prg_read;
    logic        prg_write;
    logic [7:0]  prg_din;
    logic [21:0] prg_aout;
    logic        prg_allow;
    logic [13:0] chr_ain;
    logic [21:0] chr_aout;
    logic        chr_allow;
    logic        vram_a10;
    logic        vram_ce;
    logic        cfg_commit;

    modport master (
        output ce, flags, prg_ain, prg_read, prg_write, prg_din, chr_ain,
        input  prg_aout, prg_allow, chr_aout, chr_allow, vram_a10, vram_ce, cfg_commit
    );

    modport slave (
        input  ce, flags, prg_ain, prg_read, prg_write, prg_din, chr_ain,
        output prg_aout, prg_allow, chr_aout, chr_allow, vram_a10, vram_ce, cfg_commit
    );
endinterface

// File: rtl/mmc1_sxrom_mapper.sv
// rtl/mmc1_sxrom_mapper.sv - MMC1-family (SNROM/SOROM/SUROM/SXROM) mapper
//
// Purpose: serial 5-write MMC1 register port with consecutive-write filter,
// 16 KB PRG banking with optional outer 256 KB bank, 4/8 KB CHR banking,
// banked 8 KB PRG RAM window at $6000-$7FFF and nametable mirroring.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      mmc1_sxrom_mapper_if.slave (CPU/PPU inputs, mapped outputs)
// Optional feature macro: MMC1_WRAM_DISABLE_EN
//   defined   -> prg[4]=1 disables the PRG RAM window (prg_allow=0 there)
//   undefined -> PRG RAM always enabled, prg[4] stored but unused

module mmc1_sxrom_mapper #(
    parameter int          PRG_BANK_W = 5,
    parameter int          CHR_BANK_W = 5,
    parameter int          RAM_BANK_W = 2,
    parameter logic [21:0] PRG_BASE   = 22'h000000,
    parameter logic [21:0] CHR_BASE   = 22'h200000,
    parameter logic [21:0] RAM_BASE   = 22'h3C0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mmc1_sxrom_mapper_if.slave   bus
);

    localparam logic       OUTER_EN = (PRG_BANK_W == 5);
    localparam logic [4:0] CHR_MASK = 5'((1 << CHR_BANK_W) - 1);
    localparam logic [1:0] RAM_MASK = 2'((1 << RAM_BANK_W) - 1);

    logic [4:0] ctrl_q, ctrl_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q,  prg_d;
    // Four bits are enough: the fifth bit arrives with the committing write.
    logic [3:0] shift_q, shift_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       last_wr_q, last_wr_d;
    logic       commit_q,  commit_d;

    logic       serial_wr;
    logic [4:0] new_val;

    assign serial_wr = bus.ce && bus.prg_write && bus.prg_ain[15];
    assign new_val   = {bus.prg_din[0], shift_q};

    // Serial port next state
    always_comb begin
        ctrl_d    = ctrl_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        commit_d  = 1'b0;
        if (bus.ce) begin
            last_wr_d = serial_wr;
            // A write on the cycle right after another is the dummy write of
            // a read-modify-write instruction and must be dropped.
            if (serial_wr && !last_wr_q) begin
                if (bus.prg_din[7]) begin
                    cnt_d   = 3'd0;
                    shift_d = 4'd0;
                    ctrl_d  = ctrl_q | 5'h0C;
                end else if (cnt_q != 3'd4) begin
                    shift_d = {bus.prg_din[0], shift_q[3:1]};
                    cnt_d   = cnt_q + 3'd1;
                end else begin
                    unique case (bus.prg_ain[14:13])
                        2'd0:    ctrl_d = new_val;
                        2'd1:    chr0_d = new_val;
                        2'd2:    chr1_d = new_val;
                        default: prg_d  = new_val;
                    endcase
                    cnt_d    = 3'd0;
                    shift_d  = 4'd0;
                    commit_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q    <= 5'h0C;
            chr0_q    <= 5'd0;
            chr1_q    <= 5'd0;
            prg_q     <= 5'd0;
            shift_q   <= 4'd0;
            cnt_q     <= 3'd0;
            last_wr_q <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            commit_q  <= commit_d;
        end
    end

    // Address mapping (combinational from registers)
    logic       ram_window;
    logic       ram_en;
    logic       outer;
    logic [3:0] prg_inner;
    logic [4:0] prg_sel;
    logic [4:0] chr_sel;
    logic [1:0] ram_bank;

    assign ram_window = (bus.prg_ain[15:13] == 3'b011);

`ifdef MMC1_WRAM_DISABLE_EN
    assign ram_en = !prg_q[4];
`else
    assign ram_en = 1'b1;
`endif

    always_comb begin
        // Outer 256 KB bank follows whichever CHR register is live for the
        // current PPU address (chr0 in 8 KB mode).
        if (ctrl_q[4] && bus.chr_ain[12]) begin
            outer = chr1_q[4] & OUTER_EN;
        end else begin
            outer = chr0_q[4] & OUTER_EN;
        end

        unique case (ctrl_q[3:2])
            2'b10:   prg_inner = bus.prg_ain[14] ? prg_q[3:0] : 4'h0;
            2'b11:   prg_inner = bus.prg_ain[14] ? 4'hF : prg_q[3:0];
            default: prg_inner = {prg_q[3:1], bus.prg_ain[14]};
        endcase
        prg_sel  = {outer, prg_inner};
        ram_bank = chr0_q[3:2] & RAM_MASK;

        if (ram_window) begin
            bus.prg_aout = RAM_BASE | {7'd0, ram_bank, bus.prg_ain[12:0]};
        end else begin
            bus.prg_aout = PRG_BASE | {3'd0, prg_sel, bus.prg_ain[13:0]};
        end

        if (ctrl_q[4]) begin
            chr_sel = bus.chr_ain[12] ? chr1_q : chr0_q;
        end else begin
            chr_sel = {chr0_q[4:1], bus.chr_ain[12]};
        end
        bus.chr_aout = CHR_BASE | {5'd0, chr_sel & CHR_MASK, bus.chr_ain[11:0]};

        unique case (ctrl_q[1:0])
            2'd0:    bus.vram_a10 = 1'b0;
            2'd1:    bus.vram_a10 = 1'b1;
            2'd2:    bus.vram_a10 = bus.chr_ain[10];
            default: bus.vram_a10 = bus.chr_ain[11];
        endcase
    end

    assign bus.vram_ce    = bus.chr_ain[13];
    assign bus.prg_allow  = (bus.prg_ain[15] && !bus.prg_write) || (ram_window && ram_en);
    assign bus.chr_allow  = bus.flags[15];
    assign bus.cfg_commit = commit_q;

    logic unused_ok;
    assign unused_ok = ^{bus.flags[31:16], bus.flags[14:0], bus.prg_read,
                         bus.prg_din[6:1], prg_q[4]};

endmodule

// File: tb/tb_mmc1_sxrom_mapper.sv
// tb/tb_mmc1_sxrom_mapper.sv - self-checking bench for mmc1_sxrom_mapper

module tb_mmc1_sxrom_mapper;

    localparam int PRG_BASE_I = 'h000000;
    localparam int CHR_BASE_I = 'h200000;
    localparam int RAM_BASE_I = 'h3C0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mmc1_sxrom_mapper_if bus ();

    mmc1_sxrom_mapper dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: four registers as integers, pending serial bits in a queue.
    int m_reg [4];
    bit m_q [$];
    bit m_last;
    bit m_commit;
    bit last_commit;
    int commits;

    task automatic m_reset();
        m_reg[0] = 12; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0;
        m_q.delete();
        m_last   = 1'b0;
        m_commit = 1'b0;
    endtask

    task automatic m_step(input bit ce, input bit wr, input logic [15:0] a, input logic [7:0] d);
        bit serial;
        int v;
        m_commit = 1'b0;
        if (!ce) return;
        serial = wr && a[15];
        if (serial && !m_last) begin
            if (d[7]) begin
                m_q.delete();
                m_reg[0] = m_reg[0] | 12;
            end else begin
                m_q.push_back(d[0]);
                if (m_q.size() == 5) begin
                    v = 0;
                    foreach (m_q[i]) v = v | (int'(m_q[i]) << i);
                    m_reg[a[14:13]] = v;
                    m_q.delete();
                    m_commit = 1'b1;
                end
            end
        end
        m_last = serial;
    endtask

    function automatic logic [21:0] m_prg(input logic [15:0] a, input logic [13:0] ca);
        int src, outer, inner, hi;
        if (a[15:13] == 3'b011)
            return 22'(RAM_BASE_I + ((m_reg[1] >> 2) & 3) * 8192 + int'(a) % 8192);
        src   = (((m_reg[0] >> 4) & 1) == 1 && ca[12]) ? m_reg[2] : m_reg[1];
        outer = (src >> 4) & 1;
        hi    = int'(a[14]);
        case ((m_reg[0] >> 2) & 3)
            2:       inner = hi ? (m_reg[3] & 15) : 0;
            3:       inner = hi ? 15 : (m_reg[3] & 15);
            default: inner = (m_reg[3] & 14) + hi;
        endcase
        return 22'(PRG_BASE_I + (outer * 16 + inner) * 16384 + int'(a) % 16384);
    endfunction

    function automatic logic [21:0] m_chr(input logic [13:0] ca);
        int sel;
        if (((m_reg[0] >> 4) & 1) == 1) sel = ca[12] ? m_reg[2] : m_reg[1];
        else                            sel = (m_reg[1] & 30) + int'(ca[12]);
        return 22'(CHR_BASE_I + sel * 4096 + int'(ca) % 4096);
    endfunction

    function automatic logic m_a10(input logic [13:0] ca);
        case (m_reg[0] & 3)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ca[10];
            default: return ca[11];
        endcase
    endfunction

    function automatic logic m_allow(input logic [15:0] a, input bit wr);
        bit ram_en;
`ifdef MMC1_WRAM_DISABLE_EN
        ram_en = (((m_reg[3] >> 4) & 1) == 0);
`else
        ram_en = 1'b1;
`endif
        return (a[15] && !wr) || (a[15:13] == 3'b011 && ram_en);
    endfunction

    // One CPU cycle: drive, clock, advance the model, sample 1 time unit later.
    task automatic cpu_cycle(input bit ce, input bit wr, input logic [15:0] a, input logic [7:0] d);
        bus.ce        = ce;
        bus.prg_write = wr;
        bus.prg_read  = !wr;
        bus.prg_ain   = a;
        bus.prg_din   = d;
        @(posedge clk);
        m_step(ce, wr, a, d);
        #1;
        last_commit = bus.cfg_commit;
        if (last_commit) commits++;
    endtask

    task automatic do_reset();
        bus.ce        = 1'b1;
        bus.prg_write = 1'b0;
        reset_n       = 1'b0;
        @(posedge clk);
        m_reset();
        #1;
        reset_n     = 1'b1;
        last_commit = bus.cfg_commit;
    endtask

    task automatic wr_spaced(input logic [15:0] a, input logic [4:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            cpu_cycle(1'b1, 1'b1, a, {7'd0, v[i]});
            cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        end
    endtask

    task automatic test_reset();
        bus.flags   = 32'h0000_8000;
        bus.chr_ain = 14'h0000;
        do_reset();
        checks++;
        if (last_commit !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b exp=0", last_commit); end
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h000000) begin failures++; $display("FAIL reset_prg8000 got=%h exp=000000", bus.prg_aout); end
        cpu_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h03C000) begin failures++; $display("FAIL reset_prgC000 got=%h exp=03C000", bus.prg_aout); end
        checks++;
        if (bus.chr_aout !== 22'h200000) begin failures++; $display("FAIL reset_chr got=%h exp=200000", bus.chr_aout); end
        checks++;
        if (bus.prg_allow !== 1'b1) begin failures++; $display("FAIL reset_allow got=%b exp=1", bus.prg_allow); end
        checks++;
        if (bus.chr_allow !== 1'b1) begin failures++; $display("FAIL reset_chr_allow got=%b exp=1", bus.chr_allow); end
    endtask

    task automatic test_prg_serial();
        commits = 0;
        wr_spaced(16'hE000, 5'b00101, 5);
        checks++;
        if (commits != 1) begin failures++; $display("FAIL prg_commit_count got=%0d exp=1", commits); end
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h014000) begin failures++; $display("FAIL prg_serial_map got=%h exp=014000", bus.prg_aout); end
    endtask

    task automatic test_back_to_back();
        wr_spaced(16'h8000, 5'b00000, 5);
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h010000) begin failures++; $display("FAIL mode0_8000 got=%h exp=010000", bus.prg_aout); end
        cpu_cycle(1'b1, 1'b1, 16'h8000, 8'h80);
        cpu_cycle(1'b1, 1'b1, 16'h8000, 8'h00);
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h014000) begin failures++; $display("FAIL b2b_ctrl_reset got=%h exp=014000", bus.prg_aout); end
        commits = 0;
        wr_spaced(16'hE000, 5'b00110, 4);
        checks++;
        if (commits != 0) begin failures++; $display("FAIL b2b_early_commit got=%0d exp=0", commits); end
        wr_spaced(16'hE000, 5'b00000, 1);
        checks++;
        if (commits != 1) begin failures++; $display("FAIL b2b_fifth_commit got=%0d exp=1", commits); end
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h018000) begin failures++; $display("FAIL b2b_prg_value got=%h exp=018000", bus.prg_aout); end
    endtask

    task automatic test_outer_and_ram();
        bus.chr_ain = 14'h0000;
        wr_spaced(16'hA000, 5'h1C, 5);
        wr_spaced(16'hE000, 5'h00, 5);
        cpu_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h07C000) begin failures++; $display("FAIL outer_C000 got=%h exp=07C000", bus.prg_aout); end
        cpu_cycle(1'b1, 1'b0, 16'h6000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h3C6000) begin failures++; $display("FAIL ram_bank3 got=%h exp=3C6000", bus.prg_aout); end
        checks++;
        if (bus.prg_allow !== 1'b1) begin failures++; $display("FAIL ram_allow got=%b exp=1", bus.prg_allow); end
    endtask

    task automatic test_reset_mid_sequence();
        wr_spaced(16'h8000, 5'b11111, 3);
        do_reset();
        wr_spaced(16'hC000, 5'h0A, 5);
        bus.chr_ain = 14'h0000;
        cpu_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
        checks++;
        if (bus.prg_aout !== 22'h03C000) begin failures++; $display("FAIL mid_ctrl_kept got=%h exp=03C000", bus.prg_aout); end
        checks++;
        if (bus.chr_aout !== 22'h200000) begin failures++; $display("FAIL mid_chr0_kept got=%h exp=200000", bus.chr_aout); end
        wr_spaced(16'h8000, 5'h1C, 5);
        bus.chr_ain = 14'h1000;
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
        checks++;
        if (bus.chr_aout !== 22'h20A000) begin failures++; $display("FAIL mid_chr1 got=%h exp=20A000", bus.chr_aout); end
    endtask

    task automatic test_wram_disable();
        logic exp_allow;
`ifdef MMC1_WRAM_DISABLE_EN
        exp_allow = 1'b0;
`else
        exp_allow = 1'b1;
`endif
        wr_spaced(16'hE000, 5'h10, 5);
        cpu_cycle(1'b1, 1'b0, 16'h6000, 8'h00);
        checks++;
        if (bus.prg_allow !== exp_allow) begin failures++; $display("FAIL wram_allow got=%b exp=%b", bus.prg_allow, exp_allow); end
    endtask

    task automatic test_random();
        bit          ce, wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [13:0] ca;
        logic [31:0] fl;
        for (int it = 0; it < 600; it++) begin
            if ($urandom % 80 == 0) do_reset();
            ce = ($urandom % 5) != 0;
            wr = ($urandom % 3) == 0;
            if ($urandom % 4 == 0) a = 16'h6000 | 16'($urandom % 8192);
            else                   a = 16'h8000 | 16'($urandom % 32768);
            if (!wr && ($urandom % 5 == 0)) a = 16'($urandom);
            d  = ($urandom % 10 == 0) ? (8'h80 | 8'($urandom)) : (8'($urandom) & 8'h7F);
            ca = 14'($urandom);
            fl = $urandom;
            bus.chr_ain = ca;
            bus.flags   = fl;
            cpu_cycle(ce, wr, a, d);
            checks++;
            if (bus.cfg_commit !== m_commit) begin failures++; $display("FAIL rnd_commit it=%0d got=%b exp=%b", it, bus.cfg_commit, m_commit); end
            checks++;
            if (bus.prg_aout !== m_prg(a, ca)) begin failures++; $display("FAIL rnd_prg it=%0d a=%h got=%h exp=%h", it, a, bus.prg_aout, m_prg(a, ca)); end
            checks++;
            if (bus.chr_aout !== m_chr(ca)) begin failures++; $display("FAIL rnd_chr it=%0d got=%h exp=%h", it, bus.chr_aout, m_chr(ca)); end
            checks++;
            if (bus.vram_a10 !== m_a10(ca)) begin failures++; $display("FAIL rnd_a10 it=%0d got=%b exp=%b", it, bus.vram_a10, m_a10(ca)); end
            checks++;
            if (bus.vram_ce !== ca[13]) begin failures++; $display("FAIL rnd_vram_ce it=%0d got=%b exp=%b", it, bus.vram_ce, ca[13]); end
            checks++;
            if (bus.prg_allow !== m_allow(a, wr)) begin failures++; $display("FAIL rnd_allow it=%0d got=%b exp=%b", it, bus.prg_allow, m_allow(a, wr)); end
            checks++;
            if (bus.chr_allow !== fl[15]) begin failures++; $display("FAIL rnd_chr_allow it=%0d got=%b exp=%b", it, bus.chr_allow, fl[15]); end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.ce        = 1'b1;
        bus.flags     = 32'h0;
        bus.prg_ain   = 16'h0;
        bus.prg_read  = 1'b0;
        bus.prg_write = 1'b0;
        bus.prg_din   = 8'h0;
        bus.chr_ain   = 14'h0;
        commits       = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_prg_serial();
        test_back_to_back();
        test_outer_and_ram();
        test_reset_mid_sequence();
        test_wram_disable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
